// File: rtl/gps_csr_pkg.sv
// Shared constants for the GPS multi-correlator CSR block: register map,
// field widths, bus FSM encodings and the bus byte-order helper.
package gps_csr_pkg;

  localparam logic [31:0] HW_TAG = 32'h1409_1987;

  localparam int unsigned PRN_W      = 10;
  localparam int unsigned CARR_W     = 29;
  localparam int unsigned CODE_W     = 28;
  localparam int unsigned SLEW_W     = 11;
  localparam int unsigned EPOCH_W    = 11;
  localparam int unsigned ACC_W      = 16;
  localparam int unsigned ACCUM_W    = 6 * ACC_W;
  localparam int unsigned CARRV_W    = 32;
  localparam int unsigned CODE_VAL_W = 21;
  localparam int unsigned TIME_W     = 24;

  // Per-channel register offsets (word address bits [3:0])
  localparam logic [3:0] R_PRN_KEY    = 4'h0;
  localparam logic [3:0] R_CARR_NCO   = 4'h1;
  localparam logic [3:0] R_CODE_NCO   = 4'h2;
  localparam logic [3:0] R_CODE_SLEW  = 4'h3;
  localparam logic [3:0] R_ACC_FIRST  = 4'h4;
  localparam logic [3:0] R_ACC_LAST   = 4'h9;
  localparam logic [3:0] R_CARR_VAL   = 4'hA;
  localparam logic [3:0] R_CODE_VAL   = 4'hB;
  localparam logic [3:0] R_EPOCH      = 4'hC;
  localparam logic [3:0] R_EPOCH_CHK  = 4'hD;
  localparam logic [3:0] R_EPOCH_LOAD = 4'hE;

  // Global word addresses
  localparam logic [7:0] A_CH_LIMIT    = 8'hC0;
  localparam logic [7:0] A_STATUS      = 8'hE0;
  localparam logic [7:0] A_NEW_DATA    = 8'hE1;
  localparam logic [7:0] A_TIC_COUNT   = 8'hE2;
  localparam logic [7:0] A_ACCUM_COUNT = 8'hE3;
  localparam logic [7:0] A_IRQ_MASK    = 8'hE4;
  localparam logic [7:0] A_HW_TAG      = 8'hEF;
  localparam logic [7:0] A_SW_RST      = 8'hF0;
  localparam logic [7:0] A_PROG_TIC    = 8'hF1;
  localparam logic [7:0] A_PROG_ACCUM  = 8'hF2;

  // Bus FSM encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // Bus words are big-endian relative to the internal little-endian word
  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/gps_multi_correlator_csr_if.sv
// Wishbone classic slave request/response bundle for the correlator CSR.
interface gps_multi_correlator_csr_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/gps_csr_channel_regs.sv
// One tracking channel's writable control registers and their load strobes.
module gps_csr_channel_regs
  import gps_csr_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [3:0]         reg_sel,
  input  logic [31:0]        wdata,
  output logic [PRN_W-1:0]   prn_key,
  output logic [CARR_W-1:0]  carr_nco,
  output logic [CODE_W-1:0]  code_nco,
  output logic [SLEW_W-1:0]  code_slew,
  output logic [EPOCH_W-1:0] epoch_load,
  output logic               prn_key_enable,
  output logic               slew_enable,
  output logic               epoch_enable
);

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:CARR_W];

  // Register writes; strobes fire the cycle after the accepted write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prn_key        <= '0;
      carr_nco       <= '0;
      code_nco       <= '0;
      code_slew      <= '0;
      epoch_load     <= '0;
      prn_key_enable <= 1'b0;
      slew_enable    <= 1'b0;
      epoch_enable   <= 1'b0;
    end else begin
      prn_key_enable <= wr_en && (reg_sel == R_PRN_KEY);
      slew_enable    <= wr_en && (reg_sel == R_CODE_SLEW);
      epoch_enable   <= wr_en && (reg_sel == R_EPOCH_LOAD);
      if (wr_en) begin
        case (reg_sel)
          R_PRN_KEY:    prn_key    <= wdata[PRN_W-1:0];
          R_CARR_NCO:   carr_nco   <= wdata[CARR_W-1:0];
          R_CODE_NCO:   code_nco   <= wdata[CODE_W-1:0];
          R_CODE_SLEW:  code_slew  <= wdata[SLEW_W-1:0];
          R_EPOCH_LOAD: epoch_load <= wdata[EPOCH_W-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/gps_multi_correlator_csr.sv
// Wishbone CSR block for a multi-channel GPS correlator: per-channel control
// and readback, global status/new-data latches, time-base programming, irq.
module gps_multi_correlator_csr
  import gps_csr_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned ACK_DELAY = 2
) (
  input  logic                         correlator_clk,
  input  logic                         correlator_rstn,
  gps_multi_correlator_csr_if.slave    wb,
  input  logic [NUM_CH-1:0]            ch_dump,
  input  logic [NUM_CH*ACCUM_W-1:0]    ch_accum,
  input  logic [NUM_CH*CARRV_W-1:0]    ch_carrier_val,
  input  logic [NUM_CH*CODE_VAL_W-1:0] ch_code_val,
  input  logic [NUM_CH*EPOCH_W-1:0]    ch_epoch,
  input  logic [NUM_CH*EPOCH_W-1:0]    ch_epoch_check,
  input  logic                         tic_enable,
  input  logic                         accum_enable,
  input  logic [TIME_W-1:0]            tic_count,
  input  logic [TIME_W-1:0]            accum_count,
  output logic [NUM_CH*PRN_W-1:0]      ch_prn_key,
  output logic [NUM_CH*CARR_W-1:0]     ch_carr_nco,
  output logic [NUM_CH*CODE_W-1:0]     ch_code_nco,
  output logic [NUM_CH*SLEW_W-1:0]     ch_code_slew,
  output logic [NUM_CH*EPOCH_W-1:0]    ch_epoch_load,
  output logic [NUM_CH-1:0]            ch_prn_key_enable,
  output logic [NUM_CH-1:0]            ch_slew_enable,
  output logic [NUM_CH-1:0]            ch_epoch_enable,
  output logic [TIME_W-1:0]            prog_tic,
  output logic [TIME_W-1:0]            prog_accum_int,
  output logic                         sw_rst,
  output logic                         irq
);

  localparam logic [2:0] DLY_LAST = (ACK_DELAY > 0) ? 3'(ACK_DELAY - 1) : 3'd0;

  logic [1:0]        state;
  logic [2:0]        wait_cnt;
  logic [31:0]       rd_q;
  logic [31:0]       rd_word;
  logic [31:0]       wdata;
  logic [7:0]        word_adr;
  logic [3:0]        ch_sel;
  logic [3:0]        reg_sel;
  logic              ch_mapped;
  logic              req;
  logic              accept_wr;
  logic              accept_rd;
  logic [1:0]        status;
  logic [1:0]        status_next;
  logic [NUM_CH-1:0] new_data;
  logic [NUM_CH-1:0] new_data_next;
  logic [1:0]        irq_mask;
  logic              unused_bits;

  assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[31:10], wb.wb_adr_i[1:0]};

  assign word_adr  = wb.wb_adr_i[9:2];
  assign ch_sel    = word_adr[7:4];
  assign reg_sel   = word_adr[3:0];
  assign ch_mapped = (word_adr < A_CH_LIMIT) && (32'(ch_sel) < NUM_CH);
  assign wdata     = swap32(wb.wb_dat_i);
  assign req       = wb.wb_cyc_i && wb.wb_stb_i;
  assign accept_wr = (state == ST_IDLE) && req && wb.wb_we_i;
  assign accept_rd = (state == ST_IDLE) && req && !wb.wb_we_i;

  assign wb.wb_ack_o = (state == ST_ACK);
  assign wb.wb_dat_o = rd_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    gps_csr_channel_regs u_regs (
      .clk            (correlator_clk),
      .rst_n          (correlator_rstn),
      .wr_en          (accept_wr && ch_mapped && (ch_sel == 4'(g))),
      .reg_sel        (reg_sel),
      .wdata          (wdata),
      .prn_key        (ch_prn_key[g*PRN_W +: PRN_W]),
      .carr_nco       (ch_carr_nco[g*CARR_W +: CARR_W]),
      .code_nco       (ch_code_nco[g*CODE_W +: CODE_W]),
      .code_slew      (ch_code_slew[g*SLEW_W +: SLEW_W]),
      .epoch_load     (ch_epoch_load[g*EPOCH_W +: EPOCH_W]),
      .prn_key_enable (ch_prn_key_enable[g]),
      .slew_enable    (ch_slew_enable[g]),
      .epoch_enable   (ch_epoch_enable[g])
    );
  end

  // Read mux: internal little-endian word for the addressed register
  always_comb begin
    rd_word = '0;
    if (word_adr < A_CH_LIMIT) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (ch_sel == 4'(c)) begin
          case (reg_sel)
            R_PRN_KEY:    rd_word = 32'(ch_prn_key[c*PRN_W +: PRN_W]);
            R_CARR_NCO:   rd_word = 32'(ch_carr_nco[c*CARR_W +: CARR_W]);
            R_CODE_NCO:   rd_word = 32'(ch_code_nco[c*CODE_W +: CODE_W]);
            R_CODE_SLEW:  rd_word = 32'(ch_code_slew[c*SLEW_W +: SLEW_W]);
            R_CARR_VAL:   rd_word = ch_carrier_val[c*CARRV_W +: CARRV_W];
            R_CODE_VAL:   rd_word = 32'(ch_code_val[c*CODE_VAL_W +: CODE_VAL_W]);
            R_EPOCH:      rd_word = 32'(ch_epoch[c*EPOCH_W +: EPOCH_W]);
            R_EPOCH_CHK:  rd_word = 32'(ch_epoch_check[c*EPOCH_W +: EPOCH_W]);
            R_EPOCH_LOAD: rd_word = 32'(ch_epoch_load[c*EPOCH_W +: EPOCH_W]);
            default: begin
              if (reg_sel inside {[R_ACC_FIRST:R_ACC_LAST]})
                rd_word = 32'(ch_accum[c*ACCUM_W + ACC_W*(32'(reg_sel) - 32'd4) +: ACC_W]);
            end
          endcase
        end
      end
    end else begin
      case (word_adr)
        A_STATUS:      rd_word = {30'b0, status};
        A_NEW_DATA:    rd_word = 32'(new_data);
        A_TIC_COUNT:   rd_word = 32'(tic_count);
        A_ACCUM_COUNT: rd_word = 32'(accum_count);
        A_IRQ_MASK:    rd_word = 32'(irq_mask);
        A_HW_TAG:      rd_word = HW_TAG;
        A_PROG_TIC:    rd_word = 32'(prog_tic);
        A_PROG_ACCUM:  rd_word = 32'(prog_accum_int);
        default:       rd_word = '0;
      endcase
    end
  end

  // Bus FSM: latch read data at acceptance, hold it until the ack cycle
  always_ff @(posedge correlator_clk or negedge correlator_rstn) begin
    if (!correlator_rstn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      rd_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            wait_cnt <= '0;
            if (wb.wb_we_i) begin
              rd_q  <= '0;
              state <= ST_ACK;
            end else begin
              rd_q  <= swap32(rd_word);
              state <= (ACK_DELAY == 0) ? ST_ACK : ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == DLY_LAST) state <= ST_ACK;
          else wait_cnt <= wait_cnt + 3'd1;
        end
        ST_ACK: begin
          rd_q  <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Clear-on-read and sw_rst clear only the old value; a same-cycle event survives
  always_comb begin
    status_next   = (((accept_rd && (word_adr == A_STATUS)) || sw_rst) ? 2'b00 : status)
                    | {accum_enable, tic_enable};
    new_data_next = (((accept_rd && (word_adr == A_NEW_DATA)) || sw_rst) ? '0 : new_data)
                    | ch_dump;
  end

  // Global registers, event latches, sw_rst pulse and registered irq
  always_ff @(posedge correlator_clk or negedge correlator_rstn) begin
    if (!correlator_rstn) begin
      status         <= '0;
      new_data       <= '0;
      irq_mask       <= '0;
      prog_tic       <= '0;
      prog_accum_int <= '0;
      sw_rst         <= 1'b0;
      irq            <= 1'b0;
    end else begin
      status   <= status_next;
      new_data <= new_data_next;
      irq      <= |(status_next & irq_mask);
      sw_rst   <= accept_wr && (word_adr == A_SW_RST);
      if (accept_wr) begin
        case (word_adr)
          A_IRQ_MASK:   irq_mask       <= wdata[1:0];
          A_PROG_TIC:   prog_tic       <= wdata[TIME_W-1:0];
          A_PROG_ACCUM: prog_accum_int <= wdata[TIME_W-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gps_multi_correlator_csr.sv
// Scoreboard bench for gps_multi_correlator_csr with a register-map model.
module tb_gps_multi_correlator_csr;

  localparam int NC = 4;
  localparam int AD = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  gps_multi_correlator_csr_if bus();

  logic [NC-1:0]    ch_dump;
  logic [NC*96-1:0] ch_accum;
  logic [NC*32-1:0] ch_carrier_val;
  logic [NC*21-1:0] ch_code_val;
  logic [NC*11-1:0] ch_epoch, ch_epoch_check;
  logic             tic_enable, accum_enable;
  logic [23:0]      tic_count, accum_count;
  logic [NC*10-1:0] ch_prn_key;
  logic [NC*29-1:0] ch_carr_nco;
  logic [NC*28-1:0] ch_code_nco;
  logic [NC*11-1:0] ch_code_slew, ch_epoch_load;
  logic [NC-1:0]    ch_prn_key_enable, ch_slew_enable, ch_epoch_enable;
  logic [23:0]      prog_tic, prog_accum_int;
  logic             sw_rst, irq;

  gps_multi_correlator_csr #(.NUM_CH(NC), .ACK_DELAY(AD)) dut (
    .correlator_clk    (clk),
    .correlator_rstn   (rstn),
    .wb                (bus),
    .ch_dump           (ch_dump),
    .ch_accum          (ch_accum),
    .ch_carrier_val    (ch_carrier_val),
    .ch_code_val       (ch_code_val),
    .ch_epoch          (ch_epoch),
    .ch_epoch_check    (ch_epoch_check),
    .tic_enable        (tic_enable),
    .accum_enable      (accum_enable),
    .tic_count         (tic_count),
    .accum_count       (accum_count),
    .ch_prn_key        (ch_prn_key),
    .ch_carr_nco       (ch_carr_nco),
    .ch_code_nco       (ch_code_nco),
    .ch_code_slew      (ch_code_slew),
    .ch_epoch_load     (ch_epoch_load),
    .ch_prn_key_enable (ch_prn_key_enable),
    .ch_slew_enable    (ch_slew_enable),
    .ch_epoch_enable   (ch_epoch_enable),
    .prog_tic          (prog_tic),
    .prog_accum_int    (prog_accum_int),
    .sw_rst            (sw_rst),
    .irq               (irq)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_prn [NC];
  logic [31:0] m_carr[NC];
  logic [31:0] m_code[NC];
  logic [31:0] m_slew[NC];
  logic [31:0] m_eld [NC];
  logic [1:0]  m_status;
  logic [NC-1:0] m_new;
  logic [1:0]  m_mask;
  logic [23:0] m_ptic, m_pacc;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_prn[c] = 0; m_carr[c] = 0; m_code[c] = 0; m_slew[c] = 0; m_eld[c] = 0;
    end
    m_status = 0; m_new = 0; m_mask = 0; m_ptic = 0; m_pacc = 0;
  endtask

  function automatic logic [31:0] exp_read(input logic [7:0] a);
    int unsigned ch, r;
    ch = a / 16;
    r  = a % 16;
    if (a < 8'hC0) begin
      if (ch >= NC) return 32'h0;
      case (r)
        0: return m_prn[ch];
        1: return m_carr[ch];
        2: return m_code[ch];
        3: return m_slew[ch];
        4, 5, 6, 7, 8, 9: return {16'h0, ch_accum[ch*96 + (r-4)*16 +: 16]};
        10: return ch_carrier_val[ch*32 +: 32];
        11: return {11'h0, ch_code_val[ch*21 +: 21]};
        12: return {21'h0, ch_epoch[ch*11 +: 11]};
        13: return {21'h0, ch_epoch_check[ch*11 +: 11]};
        14: return m_eld[ch];
        default: return 32'h0;
      endcase
    end
    case (a)
      8'hE0: return {30'h0, m_status};
      8'hE1: return {28'h0, m_new};
      8'hE2: return {8'h0, tic_count};
      8'hE3: return {8'h0, accum_count};
      8'hE4: return {30'h0, m_mask};
      8'hEF: return 32'h1409_1987;
      8'hF1: return {8'h0, m_ptic};
      8'hF2: return {8'h0, m_pacc};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [31:0] v);
    int unsigned ch, r;
    ch = a / 16;
    r  = a % 16;
    if (a < 8'hC0) begin
      if (ch < NC) begin
        case (r)
          0:  m_prn[ch]  = v & 32'h0000_03FF;
          1:  m_carr[ch] = v & 32'h1FFF_FFFF;
          2:  m_code[ch] = v & 32'h0FFF_FFFF;
          3:  m_slew[ch] = v & 32'h0000_07FF;
          14: m_eld[ch]  = v & 32'h0000_07FF;
          default: ;
        endcase
      end
    end else begin
      case (a)
        8'hE4: m_mask = v[1:0];
        8'hF0: begin m_status = 0; m_new = 0; end
        8'hF1: m_ptic = v[23:0];
        8'hF2: m_pacc = v[23:0];
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    logic [NC*10-1:0] e_prn;
    logic [NC*29-1:0] e_carr;
    logic [NC*28-1:0] e_code;
    logic [NC*11-1:0] e_slew, e_eld;
    for (int c = 0; c < NC; c++) begin
      e_prn[c*10 +: 10]  = m_prn[c][9:0];
      e_carr[c*29 +: 29] = m_carr[c][28:0];
      e_code[c*28 +: 28] = m_code[c][27:0];
      e_slew[c*11 +: 11] = m_slew[c][10:0];
      e_eld[c*11 +: 11]  = m_eld[c][10:0];
    end
    chk("ch_prn_key", ch_prn_key, e_prn);
    chk("ch_carr_nco", ch_carr_nco, e_carr);
    chk("ch_code_nco", ch_code_nco, e_code);
    chk("ch_code_slew", ch_code_slew, e_slew);
    chk("ch_epoch_load", ch_epoch_load, e_eld);
    chk("prog_tic", prog_tic, m_ptic);
    chk("prog_accum_int", prog_accum_int, m_pacc);
  endtask

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic        rd;
    logic [7:0]  a;
    logic [31:0] dat;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.wb_ack_o !== 1'b0) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ack", bus.wb_ack_o, 0);
      end else begin
        e = sbq.pop_front();
        chk(e.rd ? "read_data" : "write_dat_o_zero", bus.wb_dat_o, e.dat);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic xfer(input logic we, input logic [7:0] a, input logic [31:0] v,
                      input logic [NC-1:0] dump_with);
    exp_t e;
    int cyc;
    int unsigned ch, r;
    logic [NC-1:0] e_pk, e_sl, e_ep;
    logic e_sw;
    ch = a / 16;
    r  = a % 16;
    e.rd = !we;
    e.a = a;
    e.dat = we ? 32'h0 : bswap(exp_read(a));
    sbq.push_back(e);
    e_pk = '0; e_sl = '0; e_ep = '0;
    e_sw = we && (a == 8'hF0);
    if (we) begin
      if (a < 8'hC0 && ch < NC) begin
        if (r == 0)  e_pk[ch] = 1'b1;
        if (r == 3)  e_sl[ch] = 1'b1;
        if (r == 14) e_ep[ch] = 1'b1;
      end
      model_write(a, v);
    end else begin
      if (a == 8'hE0) m_status = 0;
      if (a == 8'hE1) m_new = 0;
    end
    m_new |= dump_with;

    @(negedge clk);
    bus.wb_adr_i = {22'($urandom), a, 2'($urandom)};
    bus.wb_dat_i = we ? bswap(v) : $urandom;
    bus.wb_sel_i = 4'($urandom);
    bus.wb_we_i  = we;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    ch_dump = dump_with;
    @(posedge clk);
    @(negedge clk);
    ch_dump = '0;
    cyc = 1;
    while (bus.wb_ack_o !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk(we ? "write_ack_latency" : "read_ack_latency", cyc, we ? 1 : AD + 1);
    if (we) begin
      chk("prn_key_enable", ch_prn_key_enable, e_pk);
      chk("slew_enable", ch_slew_enable, e_sl);
      chk("epoch_enable", ch_epoch_enable, e_ep);
      chk("sw_rst_pulse", sw_rst, e_sw);
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", bus.wb_ack_o, 0);
    chk("dat_o_idle_zero", bus.wb_dat_o, 0);
    chk("strobes_one_cycle", {ch_prn_key_enable, ch_slew_enable, ch_epoch_enable, sw_rst}, 0);
    chk("irq", irq, |(m_status & m_mask));
    check_outputs();
  endtask

  task automatic pulse(input logic t, input logic ac, input logic [NC-1:0] d);
    @(negedge clk);
    tic_enable = t;
    accum_enable = ac;
    ch_dump = d;
    @(negedge clk);
    tic_enable = 1'b0;
    accum_enable = 1'b0;
    ch_dump = '0;
    m_status |= {ac, t};
    m_new |= d;
    chk("irq_after_event", irq, |(m_status & m_mask));
  endtask

  task automatic randomize_inputs();
    for (int c = 0; c < NC; c++) begin
      ch_accum[c*96 +: 32]      = $urandom;
      ch_accum[c*96 + 32 +: 32] = $urandom;
      ch_accum[c*96 + 64 +: 32] = $urandom;
      ch_carrier_val[c*32 +: 32] = $urandom;
      ch_code_val[c*21 +: 21]    = 21'($urandom);
      ch_epoch[c*11 +: 11]       = 11'($urandom);
      ch_epoch_check[c*11 +: 11] = 11'($urandom);
    end
    tic_count   = 24'($urandom);
    accum_count = 24'($urandom);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    logic [7:0] gl[11];
    logic [7:0] a;
    logic we;
    gl = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hEF, 8'hF0, 8'hF1, 8'hF2, 8'hE7, 8'hFF};

    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    ch_dump = '0; tic_enable = 1'b0; accum_enable = 1'b0;
    ch_accum = '0; ch_carrier_val = '0; ch_code_val = '0;
    ch_epoch = '0; ch_epoch_check = '0; tic_count = '0; accum_count = '0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("reset_ack", bus.wb_ack_o, 0);
    chk("reset_dat_o", bus.wb_dat_o, 0);
    chk("reset_irq", irq, 0);
    chk("reset_strobes", {ch_prn_key_enable, ch_slew_enable, ch_epoch_enable, sw_rst}, 0);
    check_outputs();
    rstn = 1'b1;
    randomize_inputs();

    // prn_key write to channel 1
    xfer(1'b1, 8'h10, 32'h0000_0155, '0);
    chk("prn_key_ch1", ch_prn_key[19:10], 10'h155);

    // accumulator readback, channel 2 i_early
    ch_accum[2*96 +: 16] = 16'hBEEF;
    xfer(1'b0, 8'h24, 32'h0, '0);
    xfer(1'b0, 8'hEF, 32'h0, '0);

    // dump coincident with new_data clearing read
    xfer(1'b0, 8'hE1, 32'h0, '0);
    xfer(1'b0, 8'hE1, 32'h0, 4'b1000);
    xfer(1'b0, 8'hE1, 32'h0, '0);

    // irq masking and status clear-on-read
    xfer(1'b1, 8'hE4, 32'h2, '0);
    pulse(1'b0, 1'b1, '0);
    chk("irq_set_by_accum", irq, 1);
    xfer(1'b0, 8'hE0, 32'h0, '0);
    xfer(1'b0, 8'hE0, 32'h0, '0);
    pulse(1'b1, 1'b0, '0);
    chk("irq_masked_tic", irq, 0);
    xfer(1'b0, 8'hE0, 32'h0, '0);

    // unmapped channel 5
    xfer(1'b0, 8'h50, 32'h0, '0);
    xfer(1'b1, 8'h51, $urandom, '0);

    // sw_rst clears latches, keeps control registers
    xfer(1'b1, 8'hE4, 32'h3, '0);
    pulse(1'b1, 1'b1, 4'hF);
    xfer(1'b1, 8'hF0, $urandom, '0);
    xfer(1'b0, 8'hE0, 32'h0, '0);
    xfer(1'b0, 8'hE1, 32'h0, '0);

    // randomized traffic
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 7) == 0) randomize_inputs();
      if ($urandom_range(0, 5) == 0)
        pulse(1'($urandom), 1'($urandom), NC'($urandom));
      if ($urandom_range(0, 9) < 7) a = {4'($urandom_range(0, 5)), 4'($urandom)};
      else a = gl[$urandom_range(0, 10)];
      we = 1'($urandom);
      xfer(we, a, $urandom, we ? '0 : NC'($urandom_range(0, 3) == 0 ? $urandom : 0));
    end

    // asynchronous reset during a read wait state
    xfer(1'b1, 8'hF1, 32'h00AB_CDEF, '0);
    xfer(1'b1, 8'h00, 32'h0000_03FF, '0);
    @(negedge clk);
    bus.wb_adr_i = {22'h0, 8'h24, 2'b00};
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("wait_no_ack", bus.wb_ack_o, 0);
    chk("wait_dat_o_latched", bus.wb_dat_o, bswap(exp_read(8'h24)));
    rstn = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_ack", bus.wb_ack_o, 0);
    chk("rst_mid_dat_o", bus.wb_dat_o, 0);
    chk("rst_mid_irq", irq, 0);
    chk("rst_mid_strobes", {ch_prn_key_enable, ch_slew_enable, ch_epoch_enable, sw_rst}, 0);
    check_outputs();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_hold_ack", bus.wb_ack_o, 0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_no_ack", bus.wb_ack_o, 0);
    xfer(1'b0, 8'hEF, 32'h0, '0);
    xfer(1'b0, 8'hE4, 32'h0, '0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
